// File: rtl/de0nano_ui_ctrl.sv
// de0nano_ui_ctrl: user-I/O controller for the DE0-Nano keys and LEDs.
// Synchronises and debounces NUM_KEYS active-low buttons (level, press and
// release pulses) and drives NUM_LEDS LEDs in one of four runtime modes:
// mirror, counter, PWM-dimmed user data, and bouncing scanner.
// Optional build macro DE0_UI_LONGPRESS_MODE_EN: holding key 0 for
// LONG_PRESS_MS advances the LED mode once per hold.
module de0nano_ui_ctrl #(
  parameter int unsigned NUM_KEYS      = 2,
  parameter int unsigned NUM_LEDS      = 8,
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned DEBOUNCE_MS   = 10,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned SCAN_DIV      = 5000000,
  parameter int unsigned LONG_PRESS_MS = 1000
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] key_n_i,
  output logic [NUM_KEYS-1:0] key_level_o,
  output logic [NUM_KEYS-1:0] key_press_o,
  output logic [NUM_KEYS-1:0] key_release_o,
  input  logic [1:0]          mode_sel_i,
  input  logic                mode_load_i,
  output logic [1:0]          mode_o,
  input  logic [NUM_LEDS-1:0] led_data_i,
  input  logic [PWM_BITS-1:0] pwm_duty_i,
  output logic [NUM_LEDS-1:0] led_o
);

  // LED mode encodings
  localparam logic [1:0] MODE_MIRROR = 2'd0;
  localparam logic [1:0] MODE_COUNT  = 2'd1;
  localparam logic [1:0] MODE_USER   = 2'd2;
  localparam logic [1:0] MODE_SCAN   = 2'd3;

  // Debounce timing
  localparam int unsigned DB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DB_W   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYC - 1);

  // Tick divider
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  // Scanner position
  localparam int unsigned POS_W = $clog2(NUM_LEDS);
  localparam logic [POS_W-1:0] POS_BEFORE_TOP = POS_W'(NUM_LEDS - 2);
  localparam logic [POS_W-1:0] POS_ONE        = POS_W'(1);
  localparam logic [NUM_LEDS-1:0] LED0        = NUM_LEDS'(1);

  // Long-press threshold
  localparam int unsigned LP_CYC = CLK_HZ / 1000 * LONG_PRESS_MS;

  logic [NUM_KEYS-1:0] sync_ff1;
  logic [NUM_KEYS-1:0] sync_ff2;
  logic [DB_W-1:0]     db_cnt [NUM_KEYS];
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic                heartbeat;
  logic [POS_W-1:0]    scan_pos;
  logic                scan_up;
  logic [NUM_LEDS-1:0] scan_onehot;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] led_cnt;
  logic                cnt_up;
  logic                cnt_dn;
  logic                lp_advance;
  logic [1:0]          mode_next;

  // Two-flop synchroniser; the inversion is taken before the flops so that
  // the reset value 0 means "released" and no false press follows reset.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_ff1 <= '0;
      sync_ff2 <= '0;
    end else begin
      sync_ff1 <= ~key_n_i;
      sync_ff2 <= sync_ff1;
    end
  end

  // Per-key debounce: accept a new level after DB_CYC disagreeing cycles
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i] <= '0;
      end
      key_level_o   <= '0;
      key_press_o   <= '0;
      key_release_o <= '0;
    end else begin
      key_press_o   <= '0;
      key_release_o <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (sync_ff2[i] == key_level_o[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db_cnt[i]        <= '0;
          key_level_o[i]   <= sync_ff2[i];
          key_press_o[i]   <= sync_ff2[i];
          key_release_o[i] <= ~sync_ff2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign tick = (div_cnt == DIV_MAX);

  // Free-running tick divider and heartbeat toggle
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt   <= '0;
      heartbeat <= 1'b0;
    end else if (tick) begin
      div_cnt   <= '0;
      heartbeat <= ~heartbeat;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Scanner: direction flips as the end LED is reached, so each end LED is
  // shown for exactly one step before the bounce.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      scan_pos <= '0;
      scan_up  <= 1'b1;
    end else if (tick) begin
      if (scan_up) begin
        scan_pos <= scan_pos + 1'b1;
        if (scan_pos == POS_BEFORE_TOP) begin
          scan_up <= 1'b0;
        end
      end else begin
        scan_pos <= scan_pos - 1'b1;
        if (scan_pos == POS_ONE) begin
          scan_up <= 1'b1;
        end
      end
    end
  end

  assign scan_onehot = LED0 << scan_pos;

  // Free-running PWM phase counter
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign cnt_up = key_press_o[0];

  generate
    if (NUM_KEYS > 1) begin : g_cnt_dn
      assign cnt_dn = key_press_o[1];
    end else begin : g_no_cnt_dn
      assign cnt_dn = 1'b0;
    end
  endgenerate

  // Press counter, active only in COUNT mode; value kept across modes
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      led_cnt <= '0;
    end else if (mode_o == MODE_COUNT) begin
      if (cnt_up && !cnt_dn) begin
        led_cnt <= led_cnt + 1'b1;
      end else if (cnt_dn && !cnt_up) begin
        led_cnt <= led_cnt - 1'b1;
      end
    end
  end

`ifdef DE0_UI_LONGPRESS_MODE_EN
  localparam int unsigned LP_W = (LP_CYC > 1) ? $clog2(LP_CYC) : 1;
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LP_CYC - 1);

  logic [LP_W-1:0] hold_cnt;
  logic            hold_done;

  assign lp_advance = key_level_o[0] && !hold_done && (hold_cnt == LP_MAX);

  // Long-press timer on key 0: fires once, then idles until release
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_cnt  <= '0;
      hold_done <= 1'b0;
    end else if (!key_level_o[0]) begin
      hold_cnt  <= '0;
      hold_done <= 1'b0;
    end else if (!hold_done) begin
      if (hold_cnt == LP_MAX) begin
        hold_cnt  <= '0;
        hold_done <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  // Long-press threshold has no effect in this build.
  logic lp_cfg_unused;
  assign lp_cfg_unused = (LP_CYC != 0);
  assign lp_advance    = 1'b0;
`endif

  // Next mode: an explicit load takes priority over a long-press advance
  always_comb begin
    mode_next = mode_o;
    if (mode_load_i) begin
      mode_next = mode_sel_i;
    end else if (lp_advance) begin
      mode_next = mode_o + 2'd1;
    end
  end

  // Mode register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_o <= MODE_MIRROR;
    end else begin
      mode_o <= mode_next;
    end
  end

  // Registered LED drive selected by the current mode
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      led_o <= '0;
    end else begin
      case (mode_o)
        MODE_MIRROR: led_o <= {{(NUM_LEDS - NUM_KEYS){heartbeat}}, key_level_o};
        MODE_COUNT:  led_o <= led_cnt;
        MODE_USER:   led_o <= (pwm_cnt < pwm_duty_i) ? led_data_i : '0;
        MODE_SCAN:   led_o <= scan_onehot;
        default:     led_o <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_de0nano_ui_ctrl.sv
// tb_de0nano_ui_ctrl: directed bench for de0nano_ui_ctrl with a per-cycle
// behavioural reference model. Build with DE0_UI_LONGPRESS_MODE_EN defined
// to also cover the long-press mode advance.
module tb_de0nano_ui_ctrl;

  localparam int NUM_KEYS    = 2;
  localparam int NUM_LEDS    = 8;
  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int PWM_BITS    = 4;
  localparam int SCAN_DIV    = 3;
  localparam int DB_CYC      = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int SCAN_PERIOD = 2 * (NUM_LEDS - 1);
`ifdef DE0_UI_LONGPRESS_MODE_EN
  localparam int LP_CYC      = CLK_HZ / 1000 * 20;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_KEYS-1:0] key_n = '1;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [1:0]          mode_sel = 2'd0;
  logic                mode_load = 1'b0;
  logic [1:0]          mode;
  logic [NUM_LEDS-1:0] led_data = '0;
  logic [PWM_BITS-1:0] pwm_duty = '0;
  logic [NUM_LEDS-1:0] led;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  de0nano_ui_ctrl #(
    .NUM_KEYS(NUM_KEYS), .NUM_LEDS(NUM_LEDS), .CLK_HZ(CLK_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS), .PWM_BITS(PWM_BITS), .SCAN_DIV(SCAN_DIV),
    .LONG_PRESS_MS(20)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .key_n_i(key_n),
    .key_level_o(key_level), .key_press_o(key_press), .key_release_o(key_release),
    .mode_sel_i(mode_sel), .mode_load_i(mode_load), .mode_o(mode),
    .led_data_i(led_data), .pwm_duty_i(pwm_duty), .led_o(led)
  );

  // 10-time-unit clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NUM_KEYS-1:0] m_s1, m_s2, m_level, m_press, m_release;
  int                  m_streak [NUM_KEYS];
  int                  m_n;
  logic [1:0]          m_mode;
  int                  m_cnt;
  logic [NUM_LEDS-1:0] m_led;
  int                  m_hold;
  bit                  m_fired;

  function automatic int bounce(input int t);
    int p;
    p = t % SCAN_PERIOD;
    return (p < NUM_LEDS) ? p : SCAN_PERIOD - p;
  endfunction

  task automatic model_step();
    logic [NUM_KEYS-1:0] lvl_n, prs_n, rel_n;
    logic [NUM_LEDS-1:0] led_n;
    logic [1:0]          mode_n;
    int                  up, dn;
    bit                  adv;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_release = '0;
      for (int k = 0; k < NUM_KEYS; k++) m_streak[k] = 0;
      m_n = 0; m_mode = 2'd0; m_cnt = 0; m_led = '0; m_hold = 0; m_fired = 0;
      return;
    end
    // LEDs show the state as it stood before this edge
    case (m_mode)
      2'd0: led_n = ((((m_n / SCAN_DIV) % 2) != 0) ? 8'hFC : 8'h00) | {6'b0, m_level};
      2'd1: led_n = m_cnt[7:0];
      2'd2: led_n = ((m_n % 16) < int'(pwm_duty)) ? led_data : 8'h00;
      default: led_n = 8'h01 << bounce(m_n / SCAN_DIV);
    endcase
    if (m_mode == 2'd1) begin
      up = int'(m_press[0]);
      dn = int'(m_press[1]);
      m_cnt = (m_cnt + up - dn + 256) % 256;
    end
    adv = 0;
`ifdef DE0_UI_LONGPRESS_MODE_EN
    if (m_level[0]) begin
      if (!m_fired) begin
        m_hold++;
        if (m_hold == LP_CYC) begin adv = 1; m_fired = 1; m_hold = 0; end
      end
    end else begin
      m_hold = 0; m_fired = 0;
    end
`endif
    mode_n = mode_load ? mode_sel : (adv ? m_mode + 2'd1 : m_mode);
    // A key level flips after DB_CYC consecutive samples that disagree with it
    for (int k = 0; k < NUM_KEYS; k++) begin
      lvl_n[k] = m_level[k]; prs_n[k] = 1'b0; rel_n[k] = 1'b0;
      if (m_s2[k] == m_level[k]) begin
        m_streak[k] = 0;
      end else begin
        m_streak[k]++;
        if (m_streak[k] == DB_CYC) begin
          m_streak[k] = 0;
          lvl_n[k] = m_s2[k];
          prs_n[k] = m_s2[k];
          rel_n[k] = ~m_s2[k];
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = ~key_n;
    m_level = lvl_n; m_press = prs_n; m_release = rel_n;
    m_mode = mode_n; m_led = led_n;
    m_n++;
  endtask

  // Advance the model on every edge and compare all outputs just after it
  always @(posedge clk) begin
    model_step();
    #1;
    check("key_level", key_level, m_level);
    check("key_press", key_press, m_press);
    check("key_release", key_release, m_release);
    check("mode", mode, m_mode);
    check("led", led, m_led);
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [NUM_KEYS-1:0] mask);
    key_n = key_n & ~mask;
    cycles(8);
    key_n = key_n | mask;
    cycles(8);
  endtask

  task automatic load_mode(input logic [1:0] m);
    mode_sel  = m;
    mode_load = 1'b1;
    cycles(1);
    mode_load = 1'b0;
  endtask

  initial begin : stim
    int lit, bad, np, run, seen_top, seen_bot;
    logic [NUM_LEDS-1:0] v [45];

    cycles(3);
    check("rst_led", led, 0);
    check("rst_mode", mode, 0);
    check("rst_level", key_level, 0);
    rst_n = 1'b1;
    cycles(4);

    // glitch of 3 cycles must be ignored
    key_n[0] = 1'b0;
    cycles(3);
    key_n[0] = 1'b1;
    cycles(10);
    check("glitch_level", key_level, 0);

    // held press: pulse exactly 6 edges after the falling edge
    key_n[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("press_early", key_press, 2'b00);
    @(posedge clk);
    #1 check("press_at6", key_press, 2'b01);
    check("level_at6", key_level, 2'b01);
    @(posedge clk);
    #1 check("press_single", key_press, 2'b00);
    @(negedge clk);
    cycles(3);

    key_n[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("release_early", key_release, 2'b00);
    @(posedge clk);
    #1 check("release_at6", key_release, 2'b01);
    check("level_rel", key_level, 2'b00);
    @(negedge clk);
    cycles(4);

    // COUNT mode
    load_mode(2'd1);
    check("mode_count", mode, 1);
    repeat (3) press(2'b01);
    check("count_up3", led, 8'h03);
    repeat (4) press(2'b10);
    check("count_wrap", led, 8'hFF);
    press(2'b11);
    check("count_simul", led, 8'hFF);

    // USER mode with PWM
    led_data = 8'hA5;
    pwm_duty = 4'd4;
    load_mode(2'd2);
    cycles(3);
    lit = 0; bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      if (led == 8'hA5) lit++;
      else if (led != 8'h00) bad++;
    end
    check("pwm_lit_cycles", lit, 8);
    check("pwm_bad_values", bad, 0);
    @(negedge clk);
    pwm_duty = 4'd0;
    cycles(2);
    np = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1 if (led != 8'h00) np++;
    end
    check("pwm_duty0", np, 0);
    @(negedge clk);

    // SCAN mode: one-hot neighbour steps, 3 cycles each, single-step ends
    load_mode(2'd3);
    cycles(3);
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1 v[i] = led;
    end
    @(negedge clk);
    bad = 0; seen_top = 0; seen_bot = 0; run = -1;
    for (int i = 0; i < 45; i++) begin
      if (!$onehot(v[i])) bad++;
      if (v[i] == 8'h80) seen_top = 1;
      if (v[i] == 8'h01) seen_bot = 1;
      if (i > 0 && v[i] != v[i-1]) begin
        if (v[i] != (v[i-1] << 1) && v[i] != (v[i-1] >> 1)) bad++;
        if (run > 0 && run != SCAN_DIV) bad++;
        run = 1;
      end else if (run > 0) begin
        run++;
      end
    end
    check("scan_shape", bad, 0);
    check("scan_top", seen_top, 1);
    check("scan_bottom", seen_bot, 1);

    // asynchronous reset mid-run with both keys pressed
    key_n = 2'b00;
    cycles(8);
    rst_n = 1'b0;
    #1;
    check("arst_led", led, 0);
    check("arst_level", key_level, 0);
    check("arst_press", key_press, 0);
    check("arst_mode", mode, 0);
    @(negedge clk);
    key_n = 2'b11;
    cycles(2);
    rst_n = 1'b1;
    np = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (key_press != 0) np++;
    end
    check("no_spurious_press", np, 0);
    @(negedge clk);

`ifdef DE0_UI_LONGPRESS_MODE_EN
    // long hold advances mode once
    key_n[0] = 1'b0;
    cycles(40);
    check("lp_advance_once", mode, 1);
    key_n[0] = 1'b1;
    cycles(10);
    // load collides with the advance edge (edge 26 after the key edge)
    key_n[0] = 1'b0;
    cycles(25);
    mode_sel  = 2'd3;
    mode_load = 1'b1;
    cycles(1);
    mode_load = 1'b0;
    check("lp_load_wins", mode, 3);
    cycles(20);
    check("lp_no_second", mode, 3);
    key_n[0] = 1'b1;
    cycles(10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
